// File: rtl/router_pkg.sv
// router_pkg: shared sizes and the state encoding of the router control FSM.
package router_pkg;
    localparam int NUM_PORTS = 3;
    localparam int ADDR_W = 2;
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;
endpackage

// File: rtl/router_fsm_if.sv
// router_fsm_if: control bundle between the router FSM (master) and its surroundings (slave).
interface router_fsm_if
    import router_pkg::*;
#(
    parameter int N = NUM_PORTS,
    parameter int W = ADDR_W
);
    logic pkt_valid;
    logic [W-1:0] data_in;
    logic fifo_full;
    logic [N-1:0] fifo_empty;
    logic [N-1:0] soft_reset;
    logic parity_done;
    logic low_pkt_valid;
    logic detect_add;
    logic lfd_state;
    logic ld_state;
    logic full_state;
    logic laf_state;
    logic rst_int_reg;
    logic write_enb_reg;
    logic busy;
    logic [W-1:0] dest_addr;
    modport master (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
               write_enb_reg, busy, dest_addr
    );
    modport slave (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
               write_enb_reg, busy, dest_addr
    );
endinterface

// File: rtl/router_fsm.sv
// router_fsm: 1x3 router control FSM; decodes the header address and sequences one packet.
module router_fsm
    import router_pkg::*;
(
    input logic clock,
    input logic resetn,
    router_fsm_if.master bus
);
    localparam int PAD = 2 ** ADDR_W;
    state_t state, next_state;
    logic [ADDR_W-1:0] next_addr;
    logic [PAD-1:0] empty_pad, sreset_pad;
    // Pad the per-port flags so any address value indexes in range.
    assign empty_pad  = PAD'(bus.fifo_empty);
    assign sreset_pad = PAD'(bus.soft_reset);
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state         <= DECODE_ADDRESS;
            bus.dest_addr <= '0;
        end else begin
            state         <= next_state;
            bus.dest_addr <= next_addr;
        end
    end
    always_comb begin
        next_state = state;
        next_addr  = bus.dest_addr;
        if (state != DECODE_ADDRESS && sreset_pad[bus.dest_addr]) begin
            next_state = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS:
                    if (bus.pkt_valid && int'(bus.data_in) < NUM_PORTS) begin
                        next_addr  = bus.data_in;
                        next_state = empty_pad[bus.data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                WAIT_TILL_EMPTY:    next_state = empty_pad[bus.dest_addr] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                LOAD_FIRST_DATA:    next_state = LOAD_DATA;
                LOAD_DATA:          next_state = bus.fifo_full ? FIFO_FULL_STATE :
                                                 !bus.pkt_valid ? LOAD_PARITY : LOAD_DATA;
                FIFO_FULL_STATE:    next_state = bus.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
                LOAD_AFTER_FULL:    next_state = bus.parity_done ? DECODE_ADDRESS :
                                                 bus.low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
                LOAD_PARITY:        next_state = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: next_state = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                default:            next_state = DECODE_ADDRESS;
            endcase
        end
    end
    always_comb begin
        bus.detect_add    = state == DECODE_ADDRESS;
        bus.lfd_state     = state == LOAD_FIRST_DATA;
        bus.ld_state      = state == LOAD_DATA;
        bus.full_state    = state == FIFO_FULL_STATE;
        bus.laf_state     = state == LOAD_AFTER_FULL;
        bus.rst_int_reg   = state == CHECK_PARITY_ERROR;
        bus.write_enb_reg = state == LOAD_DATA || state == LOAD_AFTER_FULL || state == LOAD_PARITY;
        bus.busy          = !(state == DECODE_ADDRESS || state == LOAD_DATA);
    end
endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control FSM of the 1x3 router; sequences the register block (header/data/parity capture, parity check) for one packet at a time.
- Decodes the destination address from the header byte and stalls the source via busy when the target FIFO is full or not yet drained.
- Asserts the per-phase strobes consumed by the register block and the write-enable used by the synchroniser.

Parameters:
- NUM_PORTS, 3: number of output FIFOs; valid addresses 0..NUM_PORTS-1.
- ADDR_W, 2: width of the address field, data_in[ADDR_W-1:0] of the header.

Ports:
- clock  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- pkt_valid  in  1  source packet-valid; falls on the parity byte.
- data_in  in  ADDR_W  header address bits.
- fifo_full  in  1  full flag of the FIFO selected by the synchroniser.
- fifo_empty  in  NUM_PORTS  per-FIFO empty flags.
- soft_reset  in  NUM_PORTS  per-FIFO timeout soft resets.
- parity_done  in  1  from the register block.
- low_pkt_valid  in  1  from the register block.
- detect_add  out  1  DECODE_ADDRESS strobe.
- lfd_state  out  1  LOAD_FIRST_DATA strobe.
- ld_state  out  1  LOAD_DATA strobe.
- full_state  out  1  FIFO_FULL_STATE strobe.
- laf_state  out  1  LOAD_AFTER_FULL strobe.
- rst_int_reg  out  1  CHECK_PARITY_ERROR strobe.
- write_enb_reg  out  1  FIFO write enable.
- busy  out  1  stall to source.
- dest_addr  out  ADDR_W  latched destination address.

Behaviour:
- State register only; all outputs are Moore, decoded combinationally from state. dest_addr is registered.
- Reset (resetn=0 at posedge): state=DECODE_ADDRESS, dest_addr=0. Resulting outputs: detect_add=1, all other strobes, write_enb_reg and busy =0.
- Priority at each clock edge: resetn > soft_reset[dest_addr] (in any state except DECODE_ADDRESS; forces DECODE_ADDRESS) > normal transitions.
- DECODE_ADDRESS: detect_add=1, busy=0, wen=0.
  - On pkt_valid with data_in<NUM_PORTS: latch dest_addr=data_in. Go to LOAD_FIRST_DATA if fifo_empty[data_in]=1, else WAIT_TILL_EMPTY.
  - pkt_valid with data_in>=NUM_PORTS: stay; header dropped.
- WAIT_TILL_EMPTY: busy=1, wen=0. Go to LOAD_FIRST_DATA when fifo_empty[dest_addr]=1, else stay.
- LOAD_FIRST_DATA: lfd_state=1, busy=1, wen=0. Go to LOAD_DATA unconditionally (1 cycle).
- LOAD_DATA: ld_state=1, busy=0, wen=1.
  - fifo_full=1: go to FIFO_FULL_STATE (takes precedence over pkt_valid=0).
  - else pkt_valid=0: go to LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE: full_state=1, busy=1, wen=0. Go to LOAD_AFTER_FULL when fifo_full=0.
- LOAD_AFTER_FULL: laf_state=1, busy=1, wen=1.
  - parity_done=1: go to DECODE_ADDRESS.
  - else low_pkt_valid=1: go to LOAD_PARITY.
  - else go to LOAD_DATA.
- LOAD_PARITY: busy=1, wen=1. Go to CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: rst_int_reg=1, busy=1, wen=0. Go to FIFO_FULL_STATE if fifo_full=1, else DECODE_ADDRESS.
- Exactly one strobe of detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg is high per cycle, except in WAIT_TILL_EMPTY and LOAD_PARITY, where none is high.
- Unreachable encodings recover to DECODE_ADDRESS on the next edge.
- Soft reset mid-packet: remaining bytes are ignored; a new header is accepted only on pkt_valid in DECODE_ADDRESS.
- soft_reset for a port other than dest_addr has no effect.

Decomposition:
- Package router_pkg: NUM_PORTS and ADDR_W defaults; 3-bit state enum for the 8 states, with DECODE_ADDRESS=0.
- No sub-module; single always block for state/dest_addr plus a combinational next-state block and an output-decode block.

Test Plan:
- Reset: resetn=0 for 2 cycles -> detect_add=1, busy=0, wen=0, dest_addr=0.
- Empty FIFO, 3-byte payload:
  - Stimulus: header 8'h0D (addr 1) with pkt_valid=1, fifo_empty=3'b010, no full.
  - Required response: DECODE_ADDRESS -> LFD (1 cycle) -> LD (3 cycles) -> LOAD_PARITY -> CHECK_PARITY_ERROR -> DECODE_ADDRESS; rst_int_reg high exactly 1 cycle; dest_addr=1.
- Busy FIFO:
  - Stimulus: header addr 2, fifo_empty[2]=0 for 4 cycles, then 1.
  - Required response: busy=1 in WAIT_TILL_EMPTY for 4 cycles, then lfd_state=1 on the next cycle.
- FIFO full during LOAD_DATA:
  - Stimulus: fifo_full=1 for 3 cycles.
  - Required response: full_state=1, busy=1, wen=0 for 3 cycles, then laf_state=1. With low_pkt_valid=1, parity_done=0, the next state is LOAD_PARITY.
- Invalid address: header address 3 with pkt_valid=1 -> stays in DECODE_ADDRESS, lfd_state never asserts.
- Soft reset in FIFO_FULL_STATE:
  - Stimulus: dest_addr=0, soft_reset=3'b001 -> detect_add=1 on the next cycle.
  - Stimulus: soft_reset=3'b100 instead -> no state change.
